register_status_table: RTL and testbench

- Register status table for the Tomasulo dispatcher, directly downstream of tag_fifo.
- On dispatch it records the tag just popped from tag_fifo (tagout_tf) against the destination register.
- It answers source-operand lookups for the dispatch stage: is the register pending, and on which tag?
- It clears entries when the CDB broadcasts the tag that owns them. The same CDB tag is concurrently returned to tag_fifo.

---
 rtl/dispatcher_pkg.sv | 29 ++
 rtl/register_status_table_if.sv | 32 +++
 rtl/rst_lookup_port.sv | 32 +++
 rtl/register_status_table.sv | 75 +++++++
 tb/tb_register_status_table.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/dispatcher_pkg.sv
// Shared Tomasulo dispatcher definitions: widths common to tag_fifo and the
// register status table, plus the table entry type and a pending-count helper.
package dispatcher_pkg;

   localparam int NUM_REGS       = 32;
   localparam int REG_ADDR_WIDTH = 5;
   localparam int TAG_WIDTH      = 6;
   localparam int ENTRY_WIDTH    = TAG_WIDTH + 1;
   localparam int CNT_WIDTH      = REG_ADDR_WIDTH + 1;

   typedef struct packed {
      logic                 pend;
      logic [TAG_WIDTH-1:0] tag;
   } rst_entry_t;

   localparam rst_entry_t ENTRY_ZERO = '{pend: 1'b0, tag: {TAG_WIDTH{1'b0}}};

   function automatic logic [CNT_WIDTH-1:0] count_pending(
      input rst_entry_t [NUM_REGS-1:0] entries
   );
      logic [CNT_WIDTH-1:0] cnt;
      cnt = {CNT_WIDTH{1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
         cnt = cnt + CNT_WIDTH'(entries[i].pend);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/register_status_table_if.sv
// Dispatch-side bundle of the register status table: source lookups,
// destination binding, CDB completion, flush and the pending count.
interface register_status_table_if;
   import dispatcher_pkg::*;

   logic [REG_ADDR_WIDTH-1:0] rs_addr_rst;
   logic [REG_ADDR_WIDTH-1:0] rt_addr_rst;
   logic [TAG_WIDTH-1:0]      rs_tag_rst;
   logic                      rs_pend_rst;
   logic [TAG_WIDTH-1:0]      rt_tag_rst;
   logic                      rt_pend_rst;
   logic                      wen_rst;
   logic [REG_ADDR_WIDTH-1:0] rd_addr_rst;
   logic [TAG_WIDTH-1:0]      rd_tag_rst;
   logic [TAG_WIDTH-1:0]      cdb_tag_rst;
   logic                      cdb_valid_rst;
   logic                      flush_rst;
   logic [CNT_WIDTH-1:0]      pend_cnt_rst;

   modport master (
      output rs_addr_rst, rt_addr_rst, wen_rst, rd_addr_rst, rd_tag_rst,
             cdb_tag_rst, cdb_valid_rst, flush_rst,
      input  rs_tag_rst, rs_pend_rst, rt_tag_rst, rt_pend_rst, pend_cnt_rst
   );

   modport slave (
      input  rs_addr_rst, rt_addr_rst, wen_rst, rd_addr_rst, rd_tag_rst,
             cdb_tag_rst, cdb_valid_rst, flush_rst,
      output rs_tag_rst, rs_pend_rst, rt_tag_rst, rt_pend_rst, pend_cnt_rst
   );

endinterface

// File: rtl/rst_lookup_port.sv
// One combinational source-operand lookup: selects an entry and hides a
// pending bit whose tag is being broadcast on the CDB this very cycle.
module rst_lookup_port
   import dispatcher_pkg::*;
(
   input  rst_entry_t [NUM_REGS-1:0] entries_i,
   input  logic [REG_ADDR_WIDTH-1:0] addr_i,
   input  logic                      cdb_valid_i,
   input  logic [TAG_WIDTH-1:0]      cdb_tag_i,
   output logic [TAG_WIDTH-1:0]      tag_o,
   output logic                      pend_o
);

   rst_entry_t entry_s;
   logic       cdb_hit_s;

   // Entry select with register-0 override and CDB bypass
   always_comb begin
      entry_s   = entries_i[addr_i];
      cdb_hit_s = cdb_valid_i & (entry_s.tag == cdb_tag_i);
      tag_o     = {TAG_WIDTH{1'b0}};
      pend_o    = 1'b0;
      if (addr_i == {REG_ADDR_WIDTH{1'b0}}) begin
         tag_o  = {TAG_WIDTH{1'b0}};
         pend_o = 1'b0;
      end else begin
         tag_o  = entry_s.tag;
         pend_o = entry_s.pend & ~cdb_hit_s;
      end
   end

endmodule

// File: rtl/register_status_table.sv
// Register status table: binds destination registers to tag_fifo tags on
// dispatch, answers rs/rt pending lookups and releases entries on CDB tags.
module register_status_table
   import dispatcher_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   register_status_table_if.slave bus
);

   rst_entry_t [NUM_REGS-1:0] entries_q;
   rst_entry_t [NUM_REGS-1:0] entries_d;
   logic [CNT_WIDTH-1:0]      pend_cnt_q;
   logic [CNT_WIDTH-1:0]      pend_cnt_d;
   logic                      wr_en_s;

   assign wr_en_s = bus.wen_rst & (bus.rd_addr_rst != {REG_ADDR_WIDTH{1'b0}});

   // Next table state: flush beats everything, a dispatch write beats a CDB clear
   always_comb begin
      entries_d = entries_q;
      if (bus.flush_rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            entries_d[i].pend = 1'b0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.cdb_valid_rst && entries_q[i].pend &&
                (entries_q[i].tag == bus.cdb_tag_rst)) begin
               entries_d[i].pend = 1'b0;
            end else begin
               entries_d[i] = entries_q[i];
            end
         end
         if (wr_en_s) begin
            entries_d[bus.rd_addr_rst] = '{pend: 1'b1, tag: bus.rd_tag_rst};
         end else begin
            entries_d[0] = ENTRY_ZERO;
         end
      end
      pend_cnt_d = count_pending(entries_d);
   end

   // Table and pending count state; reset drops every binding without a clock
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         entries_q  <= {(NUM_REGS*ENTRY_WIDTH){1'b0}};
         pend_cnt_q <= {CNT_WIDTH{1'b0}};
      end else begin
         entries_q  <= entries_d;
         pend_cnt_q <= pend_cnt_d;
      end
   end

   assign bus.pend_cnt_rst = pend_cnt_q;

   rst_lookup_port u_rs_lookup (
      .entries_i   (entries_q),
      .addr_i      (bus.rs_addr_rst),
      .cdb_valid_i (bus.cdb_valid_rst),
      .cdb_tag_i   (bus.cdb_tag_rst),
      .tag_o       (bus.rs_tag_rst),
      .pend_o      (bus.rs_pend_rst)
   );

   rst_lookup_port u_rt_lookup (
      .entries_i   (entries_q),
      .addr_i      (bus.rt_addr_rst),
      .cdb_valid_i (bus.cdb_valid_rst),
      .cdb_tag_i   (bus.cdb_tag_rst),
      .tag_o       (bus.rt_tag_rst),
      .pend_o      (bus.rt_pend_rst)
   );

endmodule

// File: tb/tb_register_status_table.sv
// Vector-table bench for register_status_table: lookups checked before each
// edge, the registered pending count checked after it through a queue.
module tb_register_status_table;
   import dispatcher_pkg::*;

   typedef struct {
      logic                      wen;
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic [TAG_WIDTH-1:0]      rd_tag;
      logic                      cdb_v;
      logic [TAG_WIDTH-1:0]      cdb_tag;
      logic                      flush;
      logic [REG_ADDR_WIDTH-1:0] rs;
      logic [REG_ADDR_WIDTH-1:0] rt;
      logic                      rs_pend;
      logic [TAG_WIDTH-1:0]      rs_tag;
      logic                      rt_pend;
      logic [TAG_WIDTH-1:0]      rt_tag;
      logic [CNT_WIDTH-1:0]      cnt;
   } vec_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;

   vec_t                 vecs[$];
   logic [CNT_WIDTH-1:0] exp_cnt_q[$];

   register_status_table_if bus ();

   register_status_table dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic wen, input int rd, input int rd_tag,
                               input logic cdb_v, input int cdb_tag, input logic flush,
                               input int rs, input int rt,
                               input logic rs_pend, input int rs_tag,
                               input logic rt_pend, input int rt_tag, input int cnt);
      vec_t v;
      v.wen     = wen;
      v.rd      = REG_ADDR_WIDTH'(rd);
      v.rd_tag  = TAG_WIDTH'(rd_tag);
      v.cdb_v   = cdb_v;
      v.cdb_tag = TAG_WIDTH'(cdb_tag);
      v.flush   = flush;
      v.rs      = REG_ADDR_WIDTH'(rs);
      v.rt      = REG_ADDR_WIDTH'(rt);
      v.rs_pend = rs_pend;
      v.rs_tag  = TAG_WIDTH'(rs_tag);
      v.rt_pend = rt_pend;
      v.rt_tag  = TAG_WIDTH'(rt_tag);
      v.cnt     = CNT_WIDTH'(cnt);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.wen_rst       = v.wen;
      bus.rd_addr_rst   = v.rd;
      bus.rd_tag_rst    = v.rd_tag;
      bus.cdb_valid_rst = v.cdb_v;
      bus.cdb_tag_rst   = v.cdb_tag;
      bus.flush_rst     = v.flush;
      bus.rs_addr_rst   = v.rs;
      bus.rt_addr_rst   = v.rt;
   endtask

   task automatic apply(input vec_t v, input int k);
      @(negedge clk);
      drive(v);
      #2;
      chk($sformatf("v%0d rs_pend", k), bus.rs_pend_rst, v.rs_pend);
      if (v.rs_pend || v.rs == '0) chk($sformatf("v%0d rs_tag", k), bus.rs_tag_rst, v.rs_tag);
      chk($sformatf("v%0d rt_pend", k), bus.rt_pend_rst, v.rt_pend);
      if (v.rt_pend || v.rt == '0) chk($sformatf("v%0d rt_tag", k), bus.rt_tag_rst, v.rt_tag);
      exp_cnt_q.push_back(v.cnt);
      @(posedge clk);
      #1;
      if (exp_cnt_q.size() == 0) begin
         chk($sformatf("v%0d scoreboard_empty", k), 32'd1, 32'd0);
      end else begin
         chk($sformatf("v%0d pend_cnt", k), bus.pend_cnt_rst, exp_cnt_q.pop_front());
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst    = 1'b0;
      drive(mk(1'b0, 0, 0, 1'b0, 0, 1'b0, 5, 7, 1'b0, 0, 1'b0, 0, 0));
      #2;
      chk("reset rs_pend", bus.rs_pend_rst, 32'd0);
      chk("reset rs_tag", bus.rs_tag_rst, 32'd0);
      chk("reset rt_pend", bus.rt_pend_rst, 32'd0);
      chk("reset pend_cnt", bus.pend_cnt_rst, 32'd0);
      #10;
      rst = 1'b1;

      //           wen rd tag cdb ctag fl  rs rt  rsp rst rtp rtt cnt
      vecs.push_back(mk(1'b0, 0,  0, 1'b0,  0, 1'b0, 5, 7, 1'b0,  0, 1'b0,  0, 0));
      vecs.push_back(mk(1'b1, 3, 12, 1'b0,  0, 1'b0, 3, 0, 1'b0,  0, 1'b0,  0, 1));
      vecs.push_back(mk(1'b0, 0,  0, 1'b0,  0, 1'b0, 3, 3, 1'b1, 12, 1'b1, 12, 1));
      vecs.push_back(mk(1'b0, 0,  0, 1'b1, 12, 1'b0, 3, 4, 1'b0,  0, 1'b0,  0, 0));
      vecs.push_back(mk(1'b0, 0,  0, 1'b0,  0, 1'b0, 3, 3, 1'b0,  0, 1'b0,  0, 0));
      vecs.push_back(mk(1'b1, 4,  2, 1'b0,  0, 1'b0, 4, 3, 1'b0,  0, 1'b0,  0, 1));
      vecs.push_back(mk(1'b1, 4,  9, 1'b0,  0, 1'b0, 4, 3, 1'b1,  2, 1'b0,  0, 1));
      vecs.push_back(mk(1'b0, 0,  0, 1'b1,  2, 1'b0, 4, 3, 1'b1,  9, 1'b0,  0, 1));
      vecs.push_back(mk(1'b0, 0,  0, 1'b0,  0, 1'b0, 4, 4, 1'b1,  9, 1'b1,  9, 1));
      vecs.push_back(mk(1'b1, 4, 20, 1'b1,  9, 1'b0, 4, 3, 1'b0,  0, 1'b0,  0, 1));
      vecs.push_back(mk(1'b0, 0,  0, 1'b0,  0, 1'b0, 4, 4, 1'b1, 20, 1'b1, 20, 1));
      vecs.push_back(mk(1'b1, 5,  7, 1'b1, 20, 1'b0, 4, 5, 1'b0,  0, 1'b0,  0, 1));
      vecs.push_back(mk(1'b0, 0,  0, 1'b0,  0, 1'b0, 4, 5, 1'b0,  0, 1'b1,  7, 1));
      vecs.push_back(mk(1'b1, 5,  8, 1'b1,  7, 1'b0, 5, 4, 1'b0,  0, 1'b0,  0, 1));
      vecs.push_back(mk(1'b0, 0,  0, 1'b0,  0, 1'b0, 5, 4, 1'b1,  8, 1'b0,  0, 1));
      vecs.push_back(mk(1'b1, 6, 30, 1'b1, 30, 1'b0, 6, 5, 1'b0,  0, 1'b1,  8, 2));
      vecs.push_back(mk(1'b0, 0,  0, 1'b0,  0, 1'b0, 6, 5, 1'b1, 30, 1'b1,  8, 2));
      vecs.push_back(mk(1'b0, 0,  0, 1'b1,  8, 1'b0, 5, 6, 1'b0,  0, 1'b1, 30, 1));
      vecs.push_back(mk(1'b0, 0,  0, 1'b1, 30, 1'b0, 6, 5, 1'b0,  0, 1'b0,  0, 0));
      vecs.push_back(mk(1'b1, 0,  5, 1'b0,  0, 1'b0, 0, 0, 1'b0,  0, 1'b0,  0, 0));
      vecs.push_back(mk(1'b0, 0,  0, 1'b0,  0, 1'b0, 0, 6, 1'b0,  0, 1'b0,  0, 0));
      for (int i = 1; i < NUM_REGS; i++) begin
         vecs.push_back(mk(1'b1, i, i, 1'b0, 0, 1'b0, i, i - 1, 1'b0, 0,
                           (i > 1), (i > 1) ? i - 1 : 0, i));
      end
      vecs.push_back(mk(1'b0, 0,  0, 1'b0,  0, 1'b0, 31, 2, 1'b1, 31, 1'b1,  2, 31));
      vecs.push_back(mk(1'b1, 2, 40, 1'b0,  0, 1'b1, 2, 31, 1'b1,  2, 1'b1, 31, 0));
      vecs.push_back(mk(1'b0, 0,  0, 1'b0,  0, 1'b0, 2, 31, 1'b0,  0, 1'b0,  0, 0));
      vecs.push_back(mk(1'b1, 7,  3, 1'b0,  0, 1'b0, 7, 8, 1'b0,  0, 1'b0,  0, 1));
      vecs.push_back(mk(1'b1, 8,  3, 1'b0,  0, 1'b0, 7, 8, 1'b1,  3, 1'b0,  0, 2));
      vecs.push_back(mk(1'b0, 0,  0, 1'b1,  3, 1'b0, 7, 8, 1'b0,  0, 1'b0,  0, 0));
      vecs.push_back(mk(1'b1, 3, 12, 1'b0,  0, 1'b0, 3, 0, 1'b0,  0, 1'b0,  0, 1));

      foreach (vecs[k]) begin
         apply(vecs[k], k);
      end

      // Asynchronous reset between clock edges must drop r3 immediately
      @(negedge clk);
      drive(mk(1'b0, 0, 0, 1'b0, 0, 1'b0, 3, 3, 1'b1, 12, 1'b1, 12, 1));
      #1;
      chk("pre_async rs_pend", bus.rs_pend_rst, 32'd1);
      chk("pre_async pend_cnt", bus.pend_cnt_rst, 32'd1);
      rst = 1'b0;
      #1;
      chk("async rs_pend", bus.rs_pend_rst, 32'd0);
      chk("async rs_tag", bus.rs_tag_rst, 32'd0);
      chk("async pend_cnt", bus.pend_cnt_rst, 32'd0);
      #1;
      rst = 1'b1;
      apply(mk(1'b0, 0, 0, 1'b0, 0, 1'b0, 3, 5, 1'b0, 0, 1'b0, 0, 0), 999);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
